shift_issue_reg: RTL and testbench
==================================

# shift_issue_reg

Decode-to-execute pipeline register for the shift class of RV32I. Each cycle it captures one decoded-stage instruction with its register-file read data. It decodes sll/srl/sra and slli/srli/srai into the 5-bit shift control code, and selects the shift amount from the immediate or the rs2 data. It presents registered C/A/B operands to the execute-stage shifter. It also applies write-back bypass at capture, honours stall/flush, and keeps held operands coherent with write-backs during a stall.

## Interface
Parameters: none.

- CLK  in  1  clock; all state updates on posedge
- RST_X  in  1  reset; asynchronous, active-low
- ID_VALID  in  1  decode stage holds a valid instruction
- ID_INSN  in  32  instruction word
- ID_RS1D  in  32  register-file data for insn[19:15]
- ID_RS2D  in  32  register-file data for insn[24:20]
- STALL  in  1  hold register contents
- FLUSH  in  1  kill register contents; has priority over STALL
- WB_WE  in  1  write-back enable
- WB_RD  in  5  write-back destination
- WB_DATA  in  32  write-back data
- EX_VALID  out  1  register holds a live instruction
- EX_SHIFT  out  1  live instruction is a legal shift
- EX_C  out  5  shift control: 10001 sll, 10011 srl, 10010 sra, 10000 none
- EX_A  out  32  shift source operand (rs1)
- EX_B  out  5  shift amount
- EX_RD  out  5  destination register (insn[11:7])
- EX_WE  out  1  register write enable for EX result
- EX_ILL  out  1  illegal shift encoding

## Operation
- Shift decode applies when opcode insn[6:0] is 0110011 (R) or 0010011 (I) and funct3 insn[14:12] is 001 or 101.
  - funct3 001 with insn[31:25] = 0000000 -> C = 10001.
  - funct3 101 with insn[31:25] = 0000000 -> C = 10011.
  - funct3 101 with insn[31:25] = 0100000 -> C = 10010.
  - Any other insn[31:25] value: EX_ILL = 1, EX_SHIFT = 0, EX_WE = 0, C = 10000.
- Non-shift valid instruction: EX_VALID = 1, EX_SHIFT = 0, EX_ILL = 0, EX_WE = 0, C = 10000. A and B are still captured and are don't-care.
- Legal shift: EX_SHIFT = 1, EX_WE = (rd != 0).
- A source: rs1 = 0 -> 0. Else if WB_WE and WB_RD = rs1 -> WB_DATA. Else ID_RS1D.
- B source:
  - I-type -> insn[24:20].
  - R-type -> low 5 bits of rs2 data, with the same bypass rule as A (rs2 = 0 -> 0).
  - Bits [31:5] of the rs2 data are ignored.
- ID_VALID = 0 on capture -> EX_VALID, EX_SHIFT, EX_WE, EX_ILL = 0 and C = 10000.
- Update priority each posedge: FLUSH > STALL > capture.
- Stall coherence: while STALL = 1 and FLUSH = 0, the stored rs1/rs2 indices are kept internally.
  - If WB_WE = 1 and WB_RD equals the stored nonzero rs1 of a valid entry, EX_A updates to WB_DATA.
  - The same rule applies to EX_B for R-type entries, using WB_DATA[4:0].
  - All other fields hold.
- FLUSH: EX_VALID, EX_SHIFT, EX_WE, EX_ILL = 0 and C = 10000. EX_A, EX_B, EX_RD may hold.

## Timing
- Reset values (async, immediate on RST_X low): EX_VALID 0, EX_SHIFT 0, EX_WE 0, EX_ILL 0, EX_C 10000, EX_A 0, EX_B 0, EX_RD 0.
- Latency: 1 cycle. An instruction presented at edge n appears on EX_* after edge n.
- All outputs are registered; no combinational path from inputs to outputs.
- Bypass compares against WB_* in the same cycle as capture. A write-back that occurs one cycle earlier is already in the register file and is not covered here.
- STALL and FLUSH in the same cycle: flush wins; no stall-coherence update.
- Reset deasserted mid-stream: the first capture happens at the first posedge with RST_X high.

## Test plan
- Reset:
  - Stimulus: assert RST_X = 0 mid-cycle with a live entry.
  - Response: outputs go to reset values without a clock edge; EX_C = 10000.
- srai:
  - Stimulus: ID_INSN = srai x5,x6,3 (0x40335293), ID_RS1D = 0x80000000.
  - Response: next cycle C = 10010, A = 0x80000000, B = 3, RD = 5, WE = 1, SHIFT = 1.
- sll with bypass:
  - Stimulus: ID_INSN = sll x1,x2,x3, ID_RS2D = 0xFFFFFFE4, WB_WE = 1, WB_RD = 2, WB_DATA = 0x12345678.
  - Response: A = 0x12345678, B = 4, C = 10001.
- Illegal encoding:
  - Stimulus: slli with insn[31:25] = 0100000 (0x40109093).
  - Response: EX_ILL = 1, WE = 0, SHIFT = 0, C = 10000.
- Stall coherence:
  - Stimulus: capture srl x4,x7,x8. Hold STALL = 1 for 3 cycles, with WB writing x7 = 0xA5A5A5A5 in cycle 2 and x8 = 0x21 in cycle 3.
  - Response: after stall, A = 0xA5A5A5A5, B = 1, all other fields unchanged.
- STALL and FLUSH together:
  - Stimulus: STALL = 1 and FLUSH = 1 in the same cycle with a valid entry.
  - Response: EX_VALID = 0, WE = 0, C = 10000. The next capture after both drop loads normally.

Source files
------------

// File: rtl/shift_issue_reg_if.sv
// Bundle of decode-side, write-back and execute-side signals around the
// shift issue register. The slave modport is the register itself.
interface shift_issue_reg_if;
  logic        ID_VALID;
  logic [31:0] ID_INSN;
  logic [31:0] ID_RS1D;
  logic [31:0] ID_RS2D;
  logic        STALL;
  logic        FLUSH;
  logic        WB_WE;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;

  logic        EX_VALID;
  logic        EX_SHIFT;
  logic [4:0]  EX_C;
  logic [31:0] EX_A;
  logic [4:0]  EX_B;
  logic [4:0]  EX_RD;
  logic        EX_WE;
  logic        EX_ILL;

  modport master (
    output ID_VALID, ID_INSN, ID_RS1D, ID_RS2D, STALL, FLUSH,
           WB_WE, WB_RD, WB_DATA,
    input  EX_VALID, EX_SHIFT, EX_C, EX_A, EX_B, EX_RD, EX_WE, EX_ILL
  );

  modport slave (
    input  ID_VALID, ID_INSN, ID_RS1D, ID_RS2D, STALL, FLUSH,
           WB_WE, WB_RD, WB_DATA,
    output EX_VALID, EX_SHIFT, EX_C, EX_A, EX_B, EX_RD, EX_WE, EX_ILL
  );
endinterface

// File: rtl/shift_issue_reg.sv
// Decode-to-execute register for RV32I shifts: decodes the shift control code,
// forwards same-cycle write-backs into the operands, and honours stall/flush.
module shift_issue_reg (
  input  logic             CLK,
  input  logic             RST_X,
  shift_issue_reg_if.slave bus
);

  localparam logic [4:0] C_NONE = 5'b10000;
  localparam logic [4:0] C_SLL  = 5'b10001;
  localparam logic [4:0] C_SRL  = 5'b10011;
  localparam logic [4:0] C_SRA  = 5'b10010;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [2:0] F3_SL  = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // Register-file value for idx, overridden by a write-back landing this cycle.
  function automatic logic [31:0] fwd_operand(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (idx == 5'd0)                 return 32'd0;
    else if (wb_we && (wb_rd == idx)) return wb_data;
    else                             return rf_data;
  endfunction

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_shift_cls;
  logic        w_legal;
  logic        w_ill;
  logic [4:0]  w_c;
  logic [31:0] w_a;
  logic [31:0] w_rs2_op;
  logic [4:0]  w_b;
  logic        w_hold_a_hit;
  logic        w_hold_b_hit;
  logic        w_unused;

  logic        r_valid_p1;
  logic        r_shift_p1;
  logic        r_we_p1;
  logic        r_ill_p1;
  logic [4:0]  r_c_p1;
  logic [31:0] r_a_p1;
  logic [4:0]  r_b_p1;
  logic [4:0]  r_rd_p1;
  logic [4:0]  r_rs1_p1;
  logic [4:0]  r_rs2_p1;
  logic        r_b_reg_p1;

  assign w_opc  = bus.ID_INSN[6:0];
  assign w_rd   = bus.ID_INSN[11:7];
  assign w_f3   = bus.ID_INSN[14:12];
  assign w_rs1  = bus.ID_INSN[19:15];
  assign w_rs2  = bus.ID_INSN[24:20];
  assign w_f7   = bus.ID_INSN[31:25];

  assign w_is_r      = (w_opc == OPC_R);
  assign w_is_i      = (w_opc == OPC_I);
  assign w_shift_cls = (w_is_r || w_is_i) && ((w_f3 == F3_SL) || (w_f3 == F3_SR));

  always_comb begin
    w_c     = C_NONE;
    w_legal = 1'b0;
    if (w_shift_cls) begin
      if ((w_f3 == F3_SL) && (w_f7 == F7_STD)) begin
        w_c     = C_SLL;
        w_legal = 1'b1;
      end else if ((w_f3 == F3_SR) && (w_f7 == F7_STD)) begin
        w_c     = C_SRL;
        w_legal = 1'b1;
      end else if ((w_f3 == F3_SR) && (w_f7 == F7_ALT)) begin
        w_c     = C_SRA;
        w_legal = 1'b1;
      end
    end
  end

  assign w_ill = w_shift_cls && !w_legal;

  assign w_a      = fwd_operand(w_rs1, bus.ID_RS1D, bus.WB_WE, bus.WB_RD, bus.WB_DATA);
  assign w_rs2_op = fwd_operand(w_rs2, bus.ID_RS2D, bus.WB_WE, bus.WB_RD, bus.WB_DATA);
  // I-type shifts take shamt from the immediate, which occupies the rs2 field.
  assign w_b      = w_is_i ? w_rs2 : w_rs2_op[4:0];
  assign w_unused = ^w_rs2_op[31:5];

  // A held entry must not keep a stale operand when its source is written back mid-stall.
  assign w_hold_a_hit = r_valid_p1 && bus.WB_WE && (r_rs1_p1 != 5'd0) &&
                        (bus.WB_RD == r_rs1_p1);
  assign w_hold_b_hit = r_valid_p1 && r_b_reg_p1 && bus.WB_WE && (r_rs2_p1 != 5'd0) &&
                        (bus.WB_RD == r_rs2_p1);

  // ---- decode -> execute stage boundary ----
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_valid_p1 <= 1'b0;
      r_shift_p1 <= 1'b0;
      r_we_p1    <= 1'b0;
      r_ill_p1   <= 1'b0;
      r_c_p1     <= C_NONE;
      r_a_p1     <= 32'd0;
      r_b_p1     <= 5'd0;
      r_rd_p1    <= 5'd0;
      r_rs1_p1   <= 5'd0;
      r_rs2_p1   <= 5'd0;
      r_b_reg_p1 <= 1'b0;
    end else if (bus.FLUSH) begin
      r_valid_p1 <= 1'b0;
      r_shift_p1 <= 1'b0;
      r_we_p1    <= 1'b0;
      r_ill_p1   <= 1'b0;
      r_c_p1     <= C_NONE;
    end else if (bus.STALL) begin
      if (w_hold_a_hit) r_a_p1 <= bus.WB_DATA;
      if (w_hold_b_hit) r_b_p1 <= bus.WB_DATA[4:0];
    end else begin
      r_valid_p1 <= bus.ID_VALID;
      r_shift_p1 <= bus.ID_VALID && w_legal;
      r_we_p1    <= bus.ID_VALID && w_legal && (w_rd != 5'd0);
      r_ill_p1   <= bus.ID_VALID && w_ill;
      r_c_p1     <= bus.ID_VALID ? w_c : C_NONE;
      r_a_p1     <= w_a;
      r_b_p1     <= w_b;
      r_rd_p1    <= w_rd;
      r_rs1_p1   <= w_rs1;
      r_rs2_p1   <= w_rs2;
      r_b_reg_p1 <= !w_is_i;
    end
  end

  assign bus.EX_VALID = r_valid_p1;
  assign bus.EX_SHIFT = r_shift_p1;
  assign bus.EX_WE    = r_we_p1;
  assign bus.EX_ILL   = r_ill_p1;
  assign bus.EX_C     = r_c_p1;
  assign bus.EX_A     = r_a_p1;
  assign bus.EX_B     = r_b_p1;
  assign bus.EX_RD    = r_rd_p1;

endmodule

// File: tb/tb_shift_issue_reg.sv
// Self-checking bench for shift_issue_reg: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a behavioural model.
module tb_shift_issue_reg;

  logic CLK = 1'b0;
  logic RST_X = 1'b0;
  always #5 CLK = ~CLK;

  shift_issue_reg_if bus();

  shift_issue_reg dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus)
  );

  localparam logic [4:0] K_NONE = 5'b10000;
  localparam logic [4:0] K_SLL  = 5'b10001;
  localparam logic [4:0] K_SRL  = 5'b10011;
  localparam logic [4:0] K_SRA  = 5'b10010;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        v;
    logic [31:0] insn;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        ev, es, ewe, eill;
    logic [4:0]  ec;
    logic [31:0] ea;
    logic [4:0]  eb;
    logic [4:0]  erd;
    logic        cab, crd;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] insn, rs1d, rs2d,
                              input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbd,
                              input logic ev, es, ewe, eill, input logic [4:0] ec,
                              input logic [31:0] ea, input logic [4:0] eb, erd,
                              input logic cab, crd);
    vec_t r;
    r.v = v; r.insn = insn; r.rs1d = rs1d; r.rs2d = rs2d;
    r.wbwe = wbwe; r.wbrd = wbrd; r.wbd = wbd;
    r.ev = ev; r.es = es; r.ewe = ewe; r.eill = eill; r.ec = ec;
    r.ea = ea; r.eb = eb; r.erd = erd; r.cab = cab; r.crd = crd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string t, input logic ev, es, ewe, eill,
                         input logic [4:0] ec, input logic [31:0] ea,
                         input logic [4:0] eb, erd, input logic cab, crd);
    chk({t, ".valid"}, {31'd0, bus.EX_VALID}, {31'd0, ev});
    chk({t, ".shift"}, {31'd0, bus.EX_SHIFT}, {31'd0, es});
    chk({t, ".we"},    {31'd0, bus.EX_WE},    {31'd0, ewe});
    chk({t, ".ill"},   {31'd0, bus.EX_ILL},   {31'd0, eill});
    chk({t, ".c"},     {27'd0, bus.EX_C},     {27'd0, ec});
    if (cab) begin
      chk({t, ".a"}, bus.EX_A, ea);
      chk({t, ".b"}, {27'd0, bus.EX_B}, {27'd0, eb});
    end
    if (crd) chk({t, ".rd"}, {27'd0, bus.EX_RD}, {27'd0, erd});
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, rs1d, rs2d,
                       input logic st, fl, we, input logic [4:0] wrd, input logic [31:0] wd);
    bus.ID_VALID = v;
    bus.ID_INSN  = insn;
    bus.ID_RS1D  = rs1d;
    bus.ID_RS2D  = rs2d;
    bus.STALL    = st;
    bus.FLUSH    = fl;
    bus.WB_WE    = we;
    bus.WB_RD    = wrd;
    bus.WB_DATA  = wd;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference decode: look the instruction up by its full {opcode,funct3,funct7} identity.
  function automatic void ref_decode(input logic [31:0] insn, output logic legal,
                                     output logic ill, output logic [4:0] c);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = insn[6:0]; f3 = insn[14:12]; f7 = insn[31:25];
    legal = 1'b1; ill = 1'b0;
    case ({opc, f3, f7})
      {7'h33, 3'd1, 7'h00}, {7'h13, 3'd1, 7'h00}: c = K_SLL;
      {7'h33, 3'd5, 7'h00}, {7'h13, 3'd5, 7'h00}: c = K_SRL;
      {7'h33, 3'd5, 7'h20}, {7'h13, 3'd5, 7'h20}: c = K_SRA;
      default: begin
        c = K_NONE;
        legal = 1'b0;
        ill = ((opc == 7'h33) || (opc == 7'h13)) && ((f3 == 3'd1) || (f3 == 3'd5));
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_src(input logic [4:0] idx, input logic [31:0] rf,
                                          input logic we, input logic [4:0] wrd,
                                          input logic [31:0] wd);
    logic [31:0] val;
    val = rf;
    if (we && wrd == idx) val = wd;
    if (idx == 5'd0) val = 32'd0;
    return val;
  endfunction

  logic        m_v, m_s, m_we, m_ill, m_breg;
  logic [4:0]  m_c, m_b, m_rd, m_rs1, m_rs2;
  logic [31:0] m_a;

  initial begin
    tbl[0]  = mk(1'b1, 32'h40335293, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 1'b1, 1'b0, K_SRA, 32'h80000000, 5'd3, 5'd5, 1'b1, 1'b1);
    tbl[1]  = mk(1'b1, enc(7'h00, 5'd3, 5'd2, 3'd1, 5'd1, 7'h33), 32'hDEADBEEF, 32'hFFFFFFE4,
                 1'b1, 5'd2, 32'h12345678,
                 1'b1, 1'b1, 1'b1, 1'b0, K_SLL, 32'h12345678, 5'd4, 5'd1, 1'b1, 1'b1);
    tbl[2]  = mk(1'b1, 32'h40109093, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, K_NONE, 32'h0, 5'd0, 5'd1, 1'b0, 1'b1);
    tbl[3]  = mk(1'b1, enc(7'h00, 5'd11, 5'd10, 3'd5, 5'd9, 7'h33), 32'hF0F0F0F0, 32'h3F,
                 1'b1, 5'd11, 32'h7,
                 1'b1, 1'b1, 1'b1, 1'b0, K_SRL, 32'hF0F0F0F0, 5'd7, 5'd9, 1'b1, 1'b1);
    tbl[4]  = mk(1'b1, enc(7'h20, 5'd4, 5'd0, 3'd5, 5'd3, 7'h33), 32'h12345678, 32'h1D,
                 1'b1, 5'd0, 32'hFFFFFFFF,
                 1'b1, 1'b1, 1'b1, 1'b0, K_SRA, 32'h0, 5'd29, 5'd3, 1'b1, 1'b1);
    tbl[5]  = mk(1'b1, enc(7'h00, 5'd31, 5'd1, 3'd1, 5'd0, 7'h13), 32'h1, 32'hFFFF,
                 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 1'b0, 1'b0, K_SLL, 32'h1, 5'd31, 5'd0, 1'b1, 1'b1);
    tbl[6]  = mk(1'b1, enc(7'h00, 5'd7, 5'd6, 3'd0, 5'd5, 7'h33), 32'h1, 32'h2,
                 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b0, K_NONE, 32'h0, 5'd0, 5'd5, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 32'h40335293, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, K_NONE, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, enc(7'h01, 5'd2, 5'd3, 3'd5, 5'd4, 7'h33), 32'h1, 32'h2,
                 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, K_NONE, 32'h0, 5'd0, 5'd4, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, enc(7'h00, 5'd12, 5'd8, 3'd5, 5'd7, 7'h13), 32'hCAFEF00D, 32'h9,
                 1'b1, 5'd12, 32'h3,
                 1'b1, 1'b1, 1'b1, 1'b0, K_SRL, 32'hCAFEF00D, 5'd12, 5'd7, 1'b1, 1'b1);
    tbl[10] = mk(1'b1, enc(7'h20, 5'd1, 5'd1, 3'd1, 5'd2, 7'h33), 32'h1, 32'h2,
                 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, K_NONE, 32'h0, 5'd0, 5'd2, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, enc(7'h00, 5'd3, 5'd1, 3'd5, 5'd2, 7'h03), 32'h1, 32'h2,
                 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b0, K_NONE, 32'h0, 5'd0, 5'd2, 1'b0, 1'b1);

    // Reset held across edges with a live instruction presented.
    drive(1'b1, 32'h40335293, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, K_NONE, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
    #2 RST_X = 1'b1;
    tick();
    chk_all("rst_release", 1'b1, 1'b1, 1'b1, 1'b0, K_SRA, 32'h80000000, 5'd3, 5'd5, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].insn, tbl[i].rs1d, tbl[i].rs2d, 1'b0, 1'b0,
            tbl[i].wbwe, tbl[i].wbrd, tbl[i].wbd);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ewe, tbl[i].eill,
              tbl[i].ec, tbl[i].ea, tbl[i].eb, tbl[i].erd, tbl[i].cab, tbl[i].crd);
    end

    // srl x4,x7,x8 held for three stall cycles while x7 then x8 are written back.
    drive(1'b1, enc(7'h00, 5'd8, 5'd7, 3'd5, 5'd4, 7'h33), 32'h11111111, 32'h2,
          1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_all("stl_cap", 1'b1, 1'b1, 1'b1, 1'b0, K_SRL, 32'h11111111, 5'd2, 5'd4, 1'b1, 1'b1);
    drive(1'b1, 32'h40109093, 32'h99999999, 32'h99999999, 1'b1, 1'b0, 1'b1, 5'd9, 32'h77);
    tick();
    chk_all("stl_c1", 1'b1, 1'b1, 1'b1, 1'b0, K_SRL, 32'h11111111, 5'd2, 5'd4, 1'b1, 1'b1);
    drive(1'b1, 32'h40109093, 32'h99999999, 32'h99999999, 1'b1, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5);
    tick();
    chk_all("stl_c2", 1'b1, 1'b1, 1'b1, 1'b0, K_SRL, 32'hA5A5A5A5, 5'd2, 5'd4, 1'b1, 1'b1);
    drive(1'b1, 32'h40109093, 32'h99999999, 32'h99999999, 1'b1, 1'b0, 1'b1, 5'd8, 32'h21);
    tick();
    chk_all("stl_c3", 1'b1, 1'b1, 1'b1, 1'b0, K_SRL, 32'hA5A5A5A5, 5'd1, 5'd4, 1'b1, 1'b1);

    // I-type entry: a write-back to the index in the immediate field must not touch B.
    drive(1'b1, enc(7'h00, 5'd7, 5'd5, 3'd5, 5'd3, 7'h13), 32'h100, 32'h0,
          1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1F);
    tick();
    chk_all("stl_imm_b", 1'b1, 1'b1, 1'b1, 1'b0, K_SRL, 32'h100, 5'd7, 5'd3, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hBEEF);
    tick();
    chk_all("stl_imm_a", 1'b1, 1'b1, 1'b1, 1'b0, K_SRL, 32'hBEEF, 5'd7, 5'd3, 1'b1, 1'b1);

    // STALL and FLUSH together, then a stall on the dead entry, then a normal capture.
    drive(1'b1, enc(7'h00, 5'd3, 5'd2, 3'd1, 5'd6, 7'h33), 32'h0F, 32'h2,
          1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_all("sf_cap", 1'b1, 1'b1, 1'b1, 1'b0, K_SLL, 32'h0F, 5'd2, 5'd6, 1'b1, 1'b1);
    drive(1'b1, 32'h40335293, 32'h1, 32'h1, 1'b1, 1'b1, 1'b1, 5'd2, 32'h999);
    tick();
    chk_all("sf_both", 1'b0, 1'b0, 1'b0, 1'b0, K_NONE, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h40335293, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_all("sf_dead_stall", 1'b0, 1'b0, 1'b0, 1'b0, K_NONE, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, enc(7'h00, 5'd9, 5'd3, 3'd1, 5'd2, 7'h13), 32'h42, 32'h0,
          1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_all("sf_next", 1'b1, 1'b1, 1'b1, 1'b0, K_SLL, 32'h42, 5'd9, 5'd2, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle with a live entry.
    #2 RST_X = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, K_NONE, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    #2 RST_X = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();

    // Randomized traffic against the behavioural model.
    m_v = 1'b0; m_s = 1'b0; m_we = 1'b0; m_ill = 1'b0; m_c = K_NONE;
    m_a = 32'h0; m_b = 5'd0; m_rd = 5'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_breg = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic        v, st, fl, we, legal, ill;
      logic [31:0] insn, r1d, r2d, wd;
      logic [4:0]  rs1, rs2, rd, wrd, c;
      logic [6:0]  f7;
      int          k;
      v   = ($urandom_range(0, 3) != 0);
      k   = $urandom_range(0, 7);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      r1d = $urandom;
      r2d = $urandom;
      case (k)
        0: insn = enc(7'h00, rs2, rs1, 3'd1, rd, 7'h33);
        1: insn = enc(7'h00, rs2, rs1, 3'd5, rd, 7'h33);
        2: insn = enc(7'h20, rs2, rs1, 3'd5, rd, 7'h33);
        3: insn = enc(7'h00, 5'($urandom_range(0, 31)), rs1, 3'd1, rd, 7'h13);
        4: insn = enc(7'h00, 5'($urandom_range(0, 31)), rs1, 3'd5, rd, 7'h13);
        5: insn = enc(7'h20, 5'($urandom_range(0, 31)), rs1, 3'd5, rd, 7'h13);
        6: begin
          f7 = 7'($urandom_range(1, 127));
          insn = enc(f7, rs2, rs1, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5, rd,
                     ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13);
        end
        default: insn = $urandom;
      endcase
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 1) != 0);
      wrd = 5'($urandom_range(0, 7));
      wd  = $urandom;
      drive(v, insn, r1d, r2d, st, fl, we, wrd, wd);

      if (fl) begin
        m_v = 1'b0; m_s = 1'b0; m_we = 1'b0; m_ill = 1'b0; m_c = K_NONE;
      end else if (st) begin
        if (m_v && we && m_rs1 != 5'd0 && wrd == m_rs1) m_a = wd;
        if (m_v && m_breg && we && m_rs2 != 5'd0 && wrd == m_rs2) m_b = wd[4:0];
      end else begin
        ref_decode(insn, legal, ill, c);
        m_v   = v;
        m_s   = v && legal;
        m_we  = v && legal && (insn[11:7] != 5'd0);
        m_ill = v && ill;
        m_c   = v ? c : K_NONE;
        m_rd  = insn[11:7];
        m_rs1 = insn[19:15];
        m_rs2 = insn[24:20];
        m_breg = (insn[6:0] == 7'h33);
        m_a   = ref_src(insn[19:15], r1d, we, wrd, wd);
        if (insn[6:0] == 7'h13) m_b = insn[24:20];
        else begin
          r2d  = ref_src(insn[24:20], r2d, we, wrd, wd);
          m_b  = r2d[4:0];
        end
      end
      tick();
      chk_all($sformatf("rnd%0d", n), m_v, m_s, m_we, m_ill, m_c, m_a, m_b, m_rd,
              m_v && m_s, m_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
